icf3z_intc: RTL and testbench
=============================

// Module: icf3z_intc
// PURPOSE
//  Interrupt controller between the external interrupt pins and the icf3z core.
//  - Synchronises and edge-detects INT0/INT1, latches them as pending, applies the mask.
//  - Presents one prioritised request to the core, with an IRQ/IACK/IRET handshake.
//  - Software reaches mask, pending and status registers over the core port bus (PORT_ID/OUT_PORT/WSTROBE/RSTROBE).
// PARAMETERS
//  BASE_ID      8'hF0  port address of MASK; PEND = BASE_ID+1, STAT = BASE_ID+2
//  SYNC_STAGES  2      synchroniser flops per input (legal values 2..4)
//  INT1_LEVEL   0      1: INT1 is level-sensitive (pending tracks synced level, W1C ignored)
// PORTS
//  CLK       in   1  system clock, all flops on rising edge
//  xRESET_P  in   1  asynchronous, active-high reset
//  INT0_IN   in   1  raw external interrupt 0 (asynchronous)
//  INT1_IN   in   1  raw external interrupt 1 (asynchronous)
//  PORT_ID   in   8  core port address
//  OUT_PORT  in   8  core write data
//  WSTROBE   in   1  core write strobe, one cycle
//  RSTROBE   in   1  core read strobe, one cycle
//  IN_PORT   out  8  read data, registered
//  RD_HIT    out  1  1-cycle pulse: IN_PORT valid, selects this block in the core input mux
//  IRQ       out  1  interrupt request to the core
//  IVEC      out  1  source of the current request: 0 = INT0, 1 = INT1
//  IACK      in   1  1-cycle pulse: core has accepted the IRQ (entered the ISR)
//  IRET      in   1  1-cycle pulse: core has executed the return-from-interrupt
// BEHAVIOUR
//  Reset (async): all outputs 0; MASK = 8'h00; PEND = 2'b00; state = IDLE; sync/edge flops = 0.
//   - Asserting reset mid-operation aborts any request or service; pending edges are lost.
//  Registers:
//   - MASK[0] = EN0, MASK[1] = EN1, MASK[7] = GIE; bits 6:2 read as 0.
//   - PEND[1:0]: read; write 1 to clear. Read as {6'b0, PEND}.
//   - STAT: bit0 = SERVICE active, bit1 = IVEC, bit2 = IRQ. Read-only.
//  Writes: WSTROBE && PORT_ID == address updates the register on the same edge.
//  Reads:
//   - RSTROBE && PORT_ID in {BASE_ID..BASE_ID+2}: IN_PORT is loaded and RD_HIT = 1 on the next edge.
//   - Any other address: RD_HIT = 0 and IN_PORT holds its value.
//  Input path: SYNC_STAGES flops, then an edge register.
//   - Rising edge of the synced input sets PEND[n].
//   - Raw rise to PEND set: SYNC_STAGES+1 edges. Raw rise to IRQ high: SYNC_STAGES+2 edges (4 at default).
//   - INT1_LEVEL = 1: PEND[1] = synced INT1 on every cycle.
//  Pending set/clear conflicts: a set wins over a same-cycle W1C, and over a same-cycle IACK clear.
//  FSM (registered IRQ/IVEC):
//   - IDLE:
//     - If GIE && |(PEND & MASK[1:0]): IVEC = lowest index active (INT0 > INT1), IRQ = 1, go to REQ.
//     - IACK and IRET are ignored.
//   - REQ:
//     - On IACK: clear PEND[IVEC] (edge mode), IRQ = 0, go to SERVICE.
//     - If the request becomes invalid before IACK (GIE = 0, EN[IVEC] = 0, or PEND[IVEC] cleared): IRQ = 0, go to IDLE (withdrawal).
//     - IVEC is frozen while in REQ. A higher-priority arrival is not pre-emptive.
//   - SERVICE:
//     - No nesting: IRQ stays 0. New edges still latch into PEND.
//     - On IRET: go to IDLE. A request may re-assert on the next edge.
//     - IACK is ignored.
//  IACK and IRET in the same cycle: each is evaluated only in its own state; there is no double transition.
// TESTING
//  T1 reset: pulse xRESET_P mid-REQ -> IRQ = 0, IN_PORT = 0, RD_HIT = 0, MASK reads 00, PEND reads 00.
//  T2 INT0 edge: MASK = 8'h81, INT0_IN rises -> IRQ = 1, IVEC = 0 after 4 edges; IACK -> IRQ = 0, PEND = 00; IRET -> STAT = 00.
//  T3 priority: MASK = 8'h83, INT0 and INT1 rise together -> IVEC = 0 first; after IRET, IRQ re-asserts with IVEC = 1.
//  T4 masking: MASK = 8'h02, INT0 edge -> PEND = 01, no IRQ; write MASK = 8'h81 -> IRQ on the next edge.
//  T5 withdrawal and W1C: in REQ for INT1, write PEND = 8'h02 -> PEND = 00, IRQ drops next edge, state IDLE.
//     Repeat with a new INT1 edge landing in the W1C cycle -> PEND[1] stays 1.
//  T6 INT1_LEVEL = 1: INT1_IN held at 1, MASK = 8'h82 -> IRQ re-asserts after every IRET; W1C of PEND[1] has no effect.

Source files
------------

// File: rtl/icf3z_intc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : icf3z_intc
//  Brief    : Two-source interrupt controller for the icf3z core. Synchronises
//             and edge-detects INT0/INT1, latches pending bits, applies the
//             mask and drives a prioritised IRQ/IACK/IRET handshake. MASK,
//             PEND and STAT are reachable over the core port bus.
//  Revision : 1.0  initial release
// ============================================================================
module icf3z_intc #(
  parameter logic [7:0] BASE_ID     = 8'hF0,
  parameter int         SYNC_STAGES = 2,
  parameter bit         INT1_LEVEL  = 1'b0
) (
  input  logic       CLK,
  input  logic       xRESET_P,
  input  logic       INT0_IN,
  input  logic       INT1_IN,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       WSTROBE,
  input  logic       RSTROBE,
  output logic [7:0] IN_PORT,
  output logic       RD_HIT,
  output logic       IRQ,
  output logic       IVEC,
  input  logic       IACK,
  input  logic       IRET
);

  localparam logic [7:0] c_ADDR_MASK = BASE_ID;
  localparam logic [7:0] c_ADDR_PEND = BASE_ID + 8'd1;
  localparam logic [7:0] c_ADDR_STAT = BASE_ID + 8'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t                 state_q;
  logic                   irq_q;
  logic                   ivec_q;
  logic [SYNC_STAGES-1:0] sync0_q;
  logic [SYNC_STAGES-1:0] sync1_q;
  logic [1:0]             edge_q;
  logic [1:0]             pend_q;
  logic [1:0]             en_q;
  logic                   gie_q;
  logic [7:0]             in_port_q;
  logic                   rd_hit_q;

  logic [1:0] w_synced;
  logic [1:0] w_rise;
  logic       w_wr_mask;
  logic       w_wr_pend;
  logic [1:0] w_w1c;
  logic [1:0] w_ack_clr;
  logic       w_pend0_d;
  logic       w_pend1_d;
  logic       w_req_valid;
  logic       w_rd_hit;
  logic [7:0] w_rd_data;
  logic [7:0] w_stat;
  logic       w_unused;

  assign w_synced  = {sync1_q[SYNC_STAGES-1], sync0_q[SYNC_STAGES-1]};
  assign w_rise    = w_synced & ~edge_q;
  assign w_wr_mask = WSTROBE && (PORT_ID == c_ADDR_MASK);
  assign w_wr_pend = WSTROBE && (PORT_ID == c_ADDR_PEND);
  assign w_w1c     = w_wr_pend ? OUT_PORT[1:0] : 2'b00;
  // IACK only clears the source that was actually being requested.
  assign w_ack_clr = (state_q == ST_REQ && IACK) ? (ivec_q ? 2'b10 : 2'b01) : 2'b00;

  // A fresh edge always beats a same-cycle W1C or acknowledge clear.
  assign w_pend0_d = w_rise[0] | (pend_q[0] & ~w_w1c[0] & ~w_ack_clr[0]);

  generate
    if (INT1_LEVEL) begin : g_int1_level
      assign w_pend1_d = w_synced[1];
    end else begin : g_int1_edge
      assign w_pend1_d = w_rise[1] | (pend_q[1] & ~w_w1c[1] & ~w_ack_clr[1]);
    end
  endgenerate

  assign w_req_valid = gie_q & en_q[ivec_q] & pend_q[ivec_q];
  assign w_stat      = {5'b0, irq_q, ivec_q, (state_q == ST_SERVICE)};
  assign w_rd_hit    = RSTROBE && ((PORT_ID == c_ADDR_MASK) ||
                                   (PORT_ID == c_ADDR_PEND) ||
                                   (PORT_ID == c_ADDR_STAT));
  // Bits not consumed in every configuration are folded here.
  assign w_unused    = ^{OUT_PORT[6:2], w_rise[1], w_w1c[1], w_ack_clr[1]};

  // Read-data mux for the three visible registers.
  always_comb begin
    w_rd_data = 8'h00;
    if (PORT_ID == c_ADDR_MASK)      w_rd_data = {gie_q, 5'b0, en_q};
    else if (PORT_ID == c_ADDR_PEND) w_rd_data = {6'b0, pend_q};
    else if (PORT_ID == c_ADDR_STAT) w_rd_data = w_stat;
  end

  // Input synchronisers followed by the edge-history register.
  always_ff @(posedge CLK or posedge xRESET_P) begin
    if (xRESET_P) begin
      sync0_q <= '0;
      sync1_q <= '0;
      edge_q  <= 2'b00;
    end else begin
      sync0_q <= {sync0_q[SYNC_STAGES-2:0], INT0_IN};
      sync1_q <= {sync1_q[SYNC_STAGES-2:0], INT1_IN};
      edge_q  <= w_synced;
    end
  end

  // Mask and pending registers.
  always_ff @(posedge CLK or posedge xRESET_P) begin
    if (xRESET_P) begin
      en_q   <= 2'b00;
      gie_q  <= 1'b0;
      pend_q <= 2'b00;
    end else begin
      if (w_wr_mask) begin
        en_q  <= OUT_PORT[1:0];
        gie_q <= OUT_PORT[7];
      end
      pend_q <= {w_pend1_d, w_pend0_d};
    end
  end

  // Request/service handshake with registered IRQ and IVEC.
  always_ff @(posedge CLK or posedge xRESET_P) begin
    if (xRESET_P) begin
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
      ivec_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gie_q && |(pend_q & en_q)) begin
            state_q <= ST_REQ;
            irq_q   <= 1'b1;
            ivec_q  <= ~(pend_q[0] & en_q[0]);
          end
        end
        ST_REQ: begin
          if (IACK) begin
            state_q <= ST_SERVICE;
            irq_q   <= 1'b0;
          end else if (!w_req_valid) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (IRET) state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  // Registered read port; data holds when no register is addressed.
  always_ff @(posedge CLK or posedge xRESET_P) begin
    if (xRESET_P) begin
      in_port_q <= 8'h00;
      rd_hit_q  <= 1'b0;
    end else begin
      rd_hit_q <= w_rd_hit;
      if (w_rd_hit) in_port_q <= w_rd_data;
    end
  end

  assign IN_PORT = in_port_q;
  assign RD_HIT  = rd_hit_q;
  assign IRQ     = irq_q;
  assign IVEC    = ivec_q;

endmodule
`default_nettype wire

// File: tb/tb_icf3z_intc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_icf3z_intc
//  Brief    : Directed self-checking bench for icf3z_intc (edge-mode and
//             level-mode INT1 instances sharing the port bus).
//  Revision : 1.0  initial release
// ============================================================================
module tb_icf3z_intc;

  logic       CLK = 1'b0;
  logic       rst;
  logic       int0, int1, l_int0, l_int1;
  logic [7:0] pid, opd;
  logic       ws, rs, iack, iret;
  logic [7:0] in_port, l_in_port;
  logic       rd_hit, irq, ivec, l_rd_hit, l_irq, l_ivec;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] rdata, l_rdata;
  logic       rhit, l_rhit;

  always #5 CLK = ~CLK;

  icf3z_intc #(.BASE_ID(8'hF0), .SYNC_STAGES(2), .INT1_LEVEL(1'b0)) dut (
    .CLK(CLK), .xRESET_P(rst), .INT0_IN(int0), .INT1_IN(int1),
    .PORT_ID(pid), .OUT_PORT(opd), .WSTROBE(ws), .RSTROBE(rs),
    .IN_PORT(in_port), .RD_HIT(rd_hit), .IRQ(irq), .IVEC(ivec),
    .IACK(iack), .IRET(iret)
  );

  icf3z_intc #(.BASE_ID(8'hF0), .SYNC_STAGES(2), .INT1_LEVEL(1'b1)) dut_lvl (
    .CLK(CLK), .xRESET_P(rst), .INT0_IN(l_int0), .INT1_IN(l_int1),
    .PORT_ID(pid), .OUT_PORT(opd), .WSTROBE(ws), .RSTROBE(rs),
    .IN_PORT(l_in_port), .RD_HIT(l_rd_hit), .IRQ(l_irq), .IVEC(l_ivec),
    .IACK(iack), .IRET(iret)
  );

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    pid = a; opd = d; ws = 1'b1; tick(); ws = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    pid = a; rs = 1'b1; tick(); rs = 1'b0;
    rdata = in_port; rhit = rd_hit; l_rdata = l_in_port; l_rhit = l_rd_hit;
  endtask

  task automatic pulse_iack();
    iack = 1'b1; tick(); iack = 1'b0;
  endtask

  task automatic pulse_iret();
    iret = 1'b1; tick(); iret = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ticks(3);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    total++; if (in_port !== 8'h00) begin bad++; $display("FAIL reset_inport got=%h exp=00", in_port); end
    total++; if (rd_hit !== 1'b0) begin bad++; $display("FAIL reset_rdhit got=%b exp=0", rd_hit); end
    rst = 1'b0;
    tick();
    wr(8'hF0, 8'h81);
    int0 = 1'b1;
    ticks(4);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL reset_prereq_irq got=%b exp=1", irq); end
    rd(8'hF0);
    total++; if (rdata !== 8'h81) begin bad++; $display("FAIL reset_premask got=%h exp=81", rdata); end
    #2 rst = 1'b1; int0 = 1'b0;
    #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_mid_irq got=%b exp=0", irq); end
    total++; if (in_port !== 8'h00) begin bad++; $display("FAIL reset_mid_inport got=%h exp=00", in_port); end
    total++; if (rd_hit !== 1'b0) begin bad++; $display("FAIL reset_mid_rdhit got=%b exp=0", rd_hit); end
    tick();
    rst = 1'b0;
    tick();
    rd(8'hF0);
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_mask got=%h exp=00", rdata); end
    total++; if (rhit !== 1'b1) begin bad++; $display("FAIL reset_rd_hit got=%b exp=1", rhit); end
    rd(8'hF1);
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_pend got=%h exp=00", rdata); end
  endtask

  task automatic test_int0_edge();
    wr(8'hF0, 8'h81);
    int0 = 1'b1;
    ticks(3);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL int0_early_irq got=%b exp=0", irq); end
    tick();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL int0_irq got=%b exp=1", irq); end
    total++; if (ivec !== 1'b0) begin bad++; $display("FAIL int0_ivec got=%b exp=0", ivec); end
    rd(8'hF2);
    total++; if (rdata !== 8'h04) begin bad++; $display("FAIL int0_stat_req got=%h exp=04", rdata); end
    tick();
    total++; if (rd_hit !== 1'b0) begin bad++; $display("FAIL int0_rdhit_idle got=%b exp=0", rd_hit); end
    total++; if (in_port !== 8'h04) begin bad++; $display("FAIL int0_inport_hold got=%h exp=04", in_port); end
    rd(8'hF3);
    total++; if (rhit !== 1'b0) begin bad++; $display("FAIL int0_miss_hit got=%b exp=0", rhit); end
    total++; if (rdata !== 8'h04) begin bad++; $display("FAIL int0_miss_hold got=%h exp=04", rdata); end
    pulse_iack();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL int0_ack_irq got=%b exp=0", irq); end
    rd(8'hF1);
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL int0_pend_ack got=%h exp=00", rdata); end
    rd(8'hF2);
    total++; if (rdata !== 8'h01) begin bad++; $display("FAIL int0_stat_svc got=%h exp=01", rdata); end
    pulse_iret();
    rd(8'hF2);
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL int0_stat_ret got=%h exp=00", rdata); end
    int0 = 1'b0;
    ticks(4);
  endtask

  task automatic test_priority();
    wr(8'hF0, 8'h83);
    int0 = 1'b1; int1 = 1'b1;
    ticks(4);
    total++; if (irq !== 1'b1 || ivec !== 1'b0) begin bad++; $display("FAIL prio_first got=%b/%b exp=1/0", irq, ivec); end
    pulse_iack();
    rd(8'hF1);
    total++; if (rdata !== 8'h02) begin bad++; $display("FAIL prio_pend got=%h exp=02", rdata); end
    pulse_iret();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL prio_ret_irq got=%b exp=0", irq); end
    tick();
    total++; if (irq !== 1'b1 || ivec !== 1'b1) begin bad++; $display("FAIL prio_second got=%b/%b exp=1/1", irq, ivec); end
    pulse_iack();
    rd(8'hF1);
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL prio_pend_end got=%h exp=00", rdata); end
    pulse_iret();
    int0 = 1'b0; int1 = 1'b0;
    ticks(4);
  endtask

  task automatic test_masking();
    wr(8'hF0, 8'h02);
    int0 = 1'b1;
    ticks(4);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_irq got=%b exp=0", irq); end
    rd(8'hF1);
    total++; if (rdata !== 8'h01) begin bad++; $display("FAIL mask_pend got=%h exp=01", rdata); end
    wr(8'hF0, 8'h81);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_wr_edge got=%b exp=0", irq); end
    tick();
    total++; if (irq !== 1'b1 || ivec !== 1'b0) begin bad++; $display("FAIL mask_unmask got=%b/%b exp=1/0", irq, ivec); end
    pulse_iack();
    pulse_iret();
    int0 = 1'b0;
    ticks(4);
  endtask

  task automatic test_withdraw();
    wr(8'hF0, 8'h82);
    int1 = 1'b1;
    ticks(4);
    total++; if (irq !== 1'b1 || ivec !== 1'b1) begin bad++; $display("FAIL wd_req got=%b/%b exp=1/1", irq, ivec); end
    wr(8'hF1, 8'h02);
    tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL wd_irq_drop got=%b exp=0", irq); end
    rd(8'hF1);
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL wd_pend got=%h exp=00", rdata); end
    rd(8'hF2);
    total++; if ((rdata & 8'h05) !== 8'h00) begin bad++; $display("FAIL wd_stat got=%h exp=x0x0", rdata); end
    int1 = 1'b0;
    ticks(4);
    int1 = 1'b1;
    ticks(2);
    wr(8'hF1, 8'h02);
    rd(8'hF1);
    total++; if (rdata !== 8'h02) begin bad++; $display("FAIL wd_set_wins got=%h exp=02", rdata); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL wd_set_irq got=%b exp=1", irq); end
    pulse_iack();
    pulse_iret();
    int1 = 1'b0;
    ticks(4);
  endtask

  task automatic test_level();
    wr(8'hF0, 8'h82);
    l_int1 = 1'b1;
    ticks(4);
    total++; if (l_irq !== 1'b1 || l_ivec !== 1'b1) begin bad++; $display("FAIL lvl_req got=%b/%b exp=1/1", l_irq, l_ivec); end
    pulse_iack();
    total++; if (l_irq !== 1'b0) begin bad++; $display("FAIL lvl_ack got=%b exp=0", l_irq); end
    rd(8'hF1);
    total++; if (l_rdata !== 8'h02) begin bad++; $display("FAIL lvl_pend got=%h exp=02", l_rdata); end
    wr(8'hF1, 8'h02);
    rd(8'hF1);
    total++; if (l_rdata !== 8'h02) begin bad++; $display("FAIL lvl_w1c got=%h exp=02", l_rdata); end
    pulse_iret();
    tick();
    total++; if (l_irq !== 1'b1) begin bad++; $display("FAIL lvl_reassert1 got=%b exp=1", l_irq); end
    pulse_iack();
    pulse_iret();
    tick();
    total++; if (l_irq !== 1'b1) begin bad++; $display("FAIL lvl_reassert2 got=%b exp=1", l_irq); end
    l_int1 = 1'b0;
    ticks(5);
    total++; if (l_irq !== 1'b0) begin bad++; $display("FAIL lvl_release got=%b exp=0", l_irq); end
  endtask

  initial begin
    rst = 1'b1; int0 = 1'b0; int1 = 1'b0; l_int0 = 1'b0; l_int1 = 1'b0;
    pid = 8'h00; opd = 8'h00; ws = 1'b0; rs = 1'b0; iack = 1'b0; iret = 1'b0;
    test_reset();
    test_int0_edge();
    test_priority();
    test_masking();
    test_withdraw();
    test_level();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
`default_nettype wire
